// File: rtl/vfx_stream_pkg.sv
// Shared types for the video stream path: pixel word, controller states and the beat record.
package vfx_stream_pkg;

  localparam int PIXEL_W        = 12;
  localparam int DEF_IMG_WIDTH  = 320;
  localparam int DEF_IMG_HEIGHT = 240;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } ctrl_state_e;

  typedef struct packed {
    pixel_t data;
    logic   sop;
    logic   eop;
  } stream_beat_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Purpose: 2-entry registered skid buffer for stream beats.
// Latency: 1 cycle from accepted input to out_vld when empty.
// Backpressure: in_rdy is registered and drops only when both entries are held.
module stream_skid_buffer
  import vfx_stream_pkg::*;
#(
  parameter type beat_t = stream_beat_t
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  in_vld,
  output logic  in_rdy,
  input  beat_t in_dat,
  output logic  out_vld,
  input  logic  out_rdy,
  output beat_t out_dat
);

  logic [1:0] count;
  logic [1:0] count_nxt;
  beat_t      head;
  beat_t      tail;
  logic       push;
  logic       pop;

  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;
  assign out_vld = (count != 2'd0);
  assign out_dat = head;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 2'd1;
    end else if (!push && pop) begin
      count_nxt = count - 2'd1;
    end
  end

  // push with pop can only happen with one entry held, since in_rdy is low when full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      head   <= '0;
      tail   <= '0;
      in_rdy <= 1'b0;
    end else begin
      count  <= count_nxt;
      in_rdy <= (count_nxt != 2'd2);
      if (push && (count == 2'd0 || pop)) begin
        head <= in_dat;
      end else if (pop) begin
        head <= tail;
      end
      if (push && !pop && count == 2'd1) begin
        tail <= in_dat;
      end
    end
  end

endmodule

// File: rtl/frame_stream_controller.sv
// Purpose: regenerates sop/eop for WIDTH x HEIGHT frames, latches blur mode per frame, flags malformed frames.
// Latency: 1 cycle input-to-output through the skid buffer; error pulses and mode appear alongside.
// Backpressure: snk_ready drops when the 2-entry skid buffer is full. Optional stats: FRAME_STATS_EN.
module frame_stream_controller
  import vfx_stream_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int DATA_W     = PIXEL_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mode_req,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_sop,
  input  logic              snk_eop,
  output logic              src_valid,
  input  logic              src_ready,
  output logic [DATA_W-1:0] src_data,
  output logic              src_sop,
  output logic              src_eop,
  output logic              is_underage,
  output logic              err_early_sop,
  output logic              err_short,
  output logic              err_long
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0]       frame_count,
  output logic [7:0]        err_count
`endif
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  ctrl_state_e  state;
  ctrl_state_e  state_nxt;
  logic [XW-1:0] x, x_nxt, pos_x;
  logic [YW-1:0] y, y_nxt, pos_y;
  logic          xfer;
  logic          keep;
  logic          early_f, short_f, long_f;
  stream_beat_t  push_beat;
  stream_beat_t  out_beat;

  assign xfer = snk_valid & snk_ready;

  // An sop beat always restarts at (0,0); eop on an sop beat only matters if that pixel is the last one.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    pos_x     = x;
    pos_y     = y;
    keep      = 1'b0;
    early_f   = 1'b0;
    short_f   = 1'b0;
    long_f    = 1'b0;
    push_beat = '0;
    if (xfer) begin
      push_beat.data = pixel_t'(snk_data);
      if (snk_sop) begin
        keep          = 1'b1;
        push_beat.sop = 1'b1;
        pos_x         = '0;
        pos_y         = '0;
        early_f       = (state == ACTIVE);
      end else begin
        keep = (state == ACTIVE);
      end
      if (keep) begin
        if (pos_x == X_LAST && pos_y == Y_LAST) begin
          push_beat.eop = 1'b1;
          x_nxt         = '0;
          y_nxt         = '0;
          if (snk_eop) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DRAIN;
            long_f    = 1'b1;
          end
        end else if (snk_eop && !snk_sop) begin
          push_beat.eop = 1'b1;
          short_f       = 1'b1;
          state_nxt     = IDLE;
          x_nxt         = '0;
          y_nxt         = '0;
        end else begin
          state_nxt = ACTIVE;
          if (pos_x == X_LAST) begin
            x_nxt = '0;
            y_nxt = pos_y + YW'(1);
          end else begin
            x_nxt = pos_x + XW'(1);
            y_nxt = pos_y;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      is_underage   <= 1'b0;
      err_early_sop <= 1'b0;
      err_short     <= 1'b0;
      err_long      <= 1'b0;
    end else begin
      state         <= state_nxt;
      x             <= x_nxt;
      y             <= y_nxt;
      err_early_sop <= early_f;
      err_short     <= short_f;
      err_long      <= long_f;
      if (xfer && snk_sop) begin
        is_underage <= mode_req;
      end
    end
  end

  stream_skid_buffer #(
    .beat_t (stream_beat_t)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .in_vld  (keep),
    .in_rdy  (snk_ready),
    .in_dat  (push_beat),
    .out_vld (src_valid),
    .out_rdy (src_ready),
    .out_dat (out_beat)
  );

  assign src_data = DATA_W'(out_beat.data);
  assign src_sop  = out_beat.sop;
  assign src_eop  = out_beat.eop;

`ifdef FRAME_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 16'd0;
      err_count   <= 8'd0;
    end else begin
      if (src_valid && src_ready && src_eop) begin
        frame_count <= frame_count + 16'd1;
      end
      if ((err_early_sop || err_short || err_long) && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_stream_controller.sv
// Directed bench for frame_stream_controller on an 8x4 frame, with a frame-level reference model.
`timescale 1ns/1ps
module tb_frame_stream_controller;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          mode_req = 1'b0;
  logic          snk_valid = 1'b0;
  logic          snk_sop = 1'b0;
  logic          snk_eop = 1'b0;
  logic [DW-1:0] snk_data = '0;
  logic          src_ready = 1'b1;
  logic          snk_ready, src_valid, src_sop, src_eop;
  logic          is_underage, err_early_sop, err_short, err_long;
  logic [DW-1:0] src_data;
`ifdef FRAME_STATS_EN
  logic [15:0]   frame_count;
  logic [7:0]    err_count;
`endif

  frame_stream_controller #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_W     (DW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mode_req      (mode_req),
    .snk_valid     (snk_valid),
    .snk_ready     (snk_ready),
    .snk_data      (snk_data),
    .snk_sop       (snk_sop),
    .snk_eop       (snk_eop),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_data      (src_data),
    .src_sop       (src_sop),
    .src_eop       (src_eop),
    .is_underage   (is_underage),
    .err_early_sop (err_early_sop),
    .err_short     (err_short),
    .err_long      (err_long)
`ifdef FRAME_STATS_EN
    ,
    .frame_count   (frame_count),
    .err_count     (err_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames as a linear pixel index, output as a queue of expected beats.
  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } exp_t;

  exp_t        q[$];
  int          p = 0;
  bit          in_frame = 0;
  bit          m_mode = 0, m_es = 0, m_sh = 0, m_lg = 0, armed = 0;
  logic [15:0] m_frames = 0;
  int          n_out = 0, n_sop = 0, n_eop = 0, n_es = 0, n_sh = 0, n_lg = 0, n_rdy_low = 0;

  initial begin
    exp_t e;
    bit   keep;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("reset_src_valid", src_valid, 0);
        chk("reset_snk_ready", snk_ready, 0);
        chk("reset_errs", {err_early_sop, err_short, err_long}, 0);
        chk("reset_mode", is_underage, 0);
        q.delete();
        in_frame = 0; p = 0; m_mode = 0; m_es = 0; m_sh = 0; m_lg = 0; armed = 0; m_frames = 0;
      end else begin
        if (!armed) begin
          chk("ready_low_after_release", snk_ready, 0);
          armed = 1;
        end else begin
          chk("snk_ready", snk_ready, q.size() < 2);
          if (!snk_ready) n_rdy_low++;
        end
        chk("src_valid", src_valid, q.size() != 0);
        chk("err_early_sop", err_early_sop, m_es);
        chk("err_short", err_short, m_sh);
        chk("err_long", err_long, m_lg);
        chk("is_underage", is_underage, m_mode);
`ifdef FRAME_STATS_EN
        chk("frame_count", frame_count, m_frames);
`endif
        n_es += int'(err_early_sop);
        n_sh += int'(err_short);
        n_lg += int'(err_long);
        if (src_valid && src_ready) begin
          n_out++;
          n_sop += int'(src_sop);
          n_eop += int'(src_eop);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("src_data", src_data, e.d);
            chk("src_sop", src_sop, e.s);
            chk("src_eop", src_eop, e.e);
            if (e.e) m_frames++;
          end
        end
        m_es = 0; m_sh = 0; m_lg = 0;
        if (snk_valid && snk_ready) begin
          e.d = snk_data; e.s = snk_sop; e.e = 0;
          keep = in_frame;
          if (snk_sop) begin
            if (in_frame) m_es = 1;
            p = 0; m_mode = mode_req; in_frame = 1; keep = 1;
          end
          if (keep) begin
            if (p == W * H - 1) begin
              e.e = 1; in_frame = 0;
              if (!snk_eop) m_lg = 1;
            end else if (snk_eop && !snk_sop) begin
              e.e = 1; in_frame = 0; m_sh = 1;
            end else begin
              p++;
            end
            q.push_back(e);
          end
        end
      end
    end
  end

  // Output backpressure: when enabled, ready is low 3 cycles out of every 5.
  bit bp_en = 0;
  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      src_ready = !(bp_en && (c % 5 < 3));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [DW-1:0] d, input logic s, input logic e);
    int guard = 0;
    snk_valid = 1'b1; snk_data = d; snk_sop = s; snk_eop = e;
    @(negedge clk);
    while (!snk_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b_out, b_sop, b_eop, b_es, b_sh, b_lg, b_rdy;
  task automatic snap();
    b_out = n_out; b_sop = n_sop; b_eop = n_eop;
    b_es = n_es; b_sh = n_sh; b_lg = n_lg; b_rdy = n_rdy_low;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("lit_ready_at_release", snk_ready, 0);
    @(posedge clk);
    #1;
    chk("lit_ready_after_one_cycle", snk_ready, 1);
    chk("lit_reset_mode", is_underage, 0);

    // clean frame
    snap();
    mode_req = 1'b0;
    send(12'd100, 1'b1, 1'b0);
    chk("lit_latency_valid", src_valid, 1);
    chk("lit_latency_sop", src_sop, 1);
    chk("lit_latency_data", src_data, 100);
    for (int i = 1; i < 32; i++) send(12'(100 + i), 1'b0, i == 31);
    idle(4);
    chk("lit_clean_beats", n_out - b_out, 32);
    chk("lit_clean_sops", n_sop - b_sop, 1);
    chk("lit_clean_eops", n_eop - b_eop, 1);
    chk("lit_clean_errs", (n_es - b_es) + (n_sh - b_sh) + (n_lg - b_lg), 0);

    // backpressure with a mode toggle mid-frame
    snap();
    bp_en = 1;
    mode_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 10) mode_req = 1'b0;
      send(12'(200 + i), i == 0, i == 31);
    end
    idle(20);
    bp_en = 0;
    idle(3);
    chk("lit_bp_beats", n_out - b_out, 32);
    chk("lit_bp_ready_dropped", (n_rdy_low - b_rdy) > 0, 1);
    chk("lit_mode_held", is_underage, 1);

    // short frame
    snap();
    send(12'd300, 1'b1, 1'b0);
    chk("lit_mode_new_sop", is_underage, 0);
    for (int i = 1; i < 21; i++) send(12'(300 + i), 1'b0, i == 20);
    idle(4);
    chk("lit_short_beats", n_out - b_out, 21);
    chk("lit_short_eops", n_eop - b_eop, 1);
    chk("lit_short_pulse", n_sh - b_sh, 1);

    // long frame then 5 stray beats
    snap();
    for (int i = 0; i < 32; i++) send(12'(400 + i), i == 0, 1'b0);
    for (int i = 0; i < 5; i++) send(12'(500 + i), 1'b0, 1'b0);
    idle(4);
    chk("lit_long_beats", n_out - b_out, 32);
    chk("lit_long_eops", n_eop - b_eop, 1);
    chk("lit_long_pulse", n_lg - b_lg, 1);

    // next sop after drain starts a clean frame
    snap();
    mode_req = 1'b1;
    for (int i = 0; i < 32; i++) send(12'(700 + i), i == 0, i == 31);
    idle(4);
    chk("lit_after_drain_beats", n_out - b_out, 32);
    chk("lit_after_drain_mode", is_underage, 1);

    // early sop, then reset mid-frame
    snap();
    mode_req = 1'b0;
    for (int i = 0; i < 12; i++) send(12'(800 + i), i == 0, 1'b0);
    mode_req = 1'b1;
    send(12'd900, 1'b1, 1'b1);
    chk("lit_early_pulse_now", err_early_sop, 1);
    chk("lit_early_src_sop", src_sop, 1);
    chk("lit_early_data", src_data, 900);
    for (int i = 1; i < 5; i++) send(12'(900 + i), 1'b0, 1'b0);
    chk("lit_early_count", n_es - b_es, 1);
    chk("lit_early_sops", n_sop - b_sop, 2);
    chk("lit_pre_reset_valid", src_valid, 1);
    chk("lit_pre_reset_mode", is_underage, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("lit_async_valid", src_valid, 0);
    chk("lit_async_data", src_data, 0);
    chk("lit_async_sop", src_sop, 0);
    chk("lit_async_ready", snk_ready, 0);
    chk("lit_async_mode", is_underage, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    snap();
    for (int i = 0; i < 4; i++) send(12'(600 + i), 1'b0, 1'b0);
    idle(3);
    chk("lit_post_reset_dropped", n_out - b_out, 0);
    chk("lit_model_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
